// File: rtl/countdown_mmss_if.sv
// Control and digit bus for the MM:SS countdown timer.
// Carries the tick/load/start_stop strobes and BCD preset inward, and the
// registered BCD digits plus run/done status outward.
interface countdown_mmss_if;
  // Strobes and preset, driven by the controller side
  logic       tick;
  logic       load;
  logic       start_stop;
  logic [3:0] preset_m1;
  logic [3:0] preset_m0;
  logic [3:0] preset_s1;
  logic [3:0] preset_s0;

  // Registered timer state, driven by the timer
  logic [3:0] min_s1;
  logic [3:0] min_s0;
  logic [3:0] sec_s1;
  logic [3:0] sec_s0;
  logic       running;
  logic       done;
  logic       done_pulse;

  // Controller / display side
  modport master (
    output tick, load, start_stop,
    output preset_m1, preset_m0, preset_s1, preset_s0,
    input  min_s1, min_s0, sec_s1, sec_s0,
    input  running, done, done_pulse
  );

  // Timer side
  modport slave (
    input  tick, load, start_stop,
    input  preset_m1, preset_m0, preset_s1, preset_s0,
    output min_s1, min_s0, sec_s1, sec_s0,
    output running, done, done_pulse
  );
endinterface

// File: rtl/countdown_mmss.sv
// Purpose: four-digit BCD MM:SS countdown timer with IDLE/RUN/PAUSE/DONE control and borrow chain.
// Latency: every input acts at the next clk edge; all outputs are registered (no comb in->out path).
// Backpressure: none; strobes are single-cycle and always accepted (priority load > start_stop > tick).
// Ports: clk, rst_n (async active-low); bus.slave carries tick/load/start_stop, BCD preset,
//        BCD digit outputs, running, done and the one-cycle done_pulse.
module countdown_mmss (
  input  logic                   clk,
  input  logic                   rst_n,
  countdown_mmss_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_s1_q, min_s1_d;
  logic [3:0] min_s0_q, min_s0_d;
  logic [3:0] sec_s1_q, sec_s1_d;
  logic [3:0] sec_s0_q, sec_s0_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       done_pulse_q, done_pulse_d;

  logic       at_zero;
  logic       at_one;

  function automatic logic [3:0] clamp_tens(input logic [3:0] d);
    return (d > 4'd5) ? 4'd5 : d;
  endfunction

  function automatic logic [3:0] clamp_units(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign at_zero = (min_s1_q == 4'd0) && (min_s0_q == 4'd0) &&
                   (sec_s1_q == 4'd0) && (sec_s0_q == 4'd0);
  // 00:01 is the only value whose decrement lands on 00:00
  assign at_one  = (min_s1_q == 4'd0) && (min_s0_q == 4'd0) &&
                   (sec_s1_q == 4'd0) && (sec_s0_q == 4'd1);

  always_comb begin
    state_d      = state_q;
    min_s1_d     = min_s1_q;
    min_s0_d     = min_s0_q;
    sec_s1_d     = sec_s1_q;
    sec_s0_d     = sec_s0_q;
    done_pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          min_s1_d = clamp_tens(bus.preset_m1);
          min_s0_d = clamp_units(bus.preset_m0);
          sec_s1_d = clamp_tens(bus.preset_s1);
          sec_s0_d = clamp_units(bus.preset_s0);
        end else if (bus.start_stop && !at_zero) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // load has no effect while counting; start_stop wins over a same-cycle tick
        if (bus.start_stop) begin
          state_d = ST_PAUSE;
        end else if (bus.tick) begin
          if (sec_s0_q != 4'd0) begin
            sec_s0_d = sec_s0_q - 4'd1;
          end else begin
            sec_s0_d = 4'd9;
            if (sec_s1_q != 4'd0) begin
              sec_s1_d = sec_s1_q - 4'd1;
            end else begin
              sec_s1_d = 4'd5;
              if (min_s0_q != 4'd0) begin
                min_s0_d = min_s0_q - 4'd1;
              end else begin
                min_s0_d = 4'd9;
                // RUN is never at 00:00, so a borrow reaching here implies min_s1 > 0
                min_s1_d = min_s1_q - 4'd1;
              end
            end
          end
          if (at_one) begin
            state_d      = ST_DONE;
            done_pulse_d = 1'b1;
          end
        end
      end

      ST_PAUSE, ST_DONE: begin
        if (bus.load) begin
          min_s1_d = clamp_tens(bus.preset_m1);
          min_s0_d = clamp_units(bus.preset_m0);
          sec_s1_d = clamp_tens(bus.preset_s1);
          sec_s0_d = clamp_units(bus.preset_s0);
          state_d  = ST_IDLE;
        end else if (bus.start_stop) begin
          state_d = (state_q == ST_PAUSE) ? ST_RUN : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered copies of the next state
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      min_s1_q     <= 4'd0;
      min_s0_q     <= 4'd0;
      sec_s1_q     <= 4'd0;
      sec_s0_q     <= 4'd0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_s1_q     <= min_s1_d;
      min_s0_q     <= min_s0_d;
      sec_s1_q     <= sec_s1_d;
      sec_s0_q     <= sec_s0_d;
      running_q    <= running_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign bus.min_s1     = min_s1_q;
  assign bus.min_s0     = min_s0_q;
  assign bus.sec_s1     = sec_s1_q;
  assign bus.sec_s0     = sec_s0_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: directed scenarios plus a randomized run, all
// checked against a model that tracks remaining time as plain seconds.
module tb_countdown_mmss;

  logic clk;
  logic rst_n;

  countdown_mmss_if bus ();

  countdown_mmss dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: remaining seconds and a coarse mode
  // mode: 0 idle, 1 run, 2 pause, 3 done
  int m_total = 0;
  int m_mode  = 0;
  bit m_pulse = 1'b0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int preset_secs(input logic [15:0] p);
    int m1, m0, s1, s0;
    m1 = min_i(int'(p[15:12]), 5);
    m0 = min_i(int'(p[11:8]), 9);
    s1 = min_i(int'(p[7:4]), 5);
    s0 = min_i(int'(p[3:0]), 9);
    return (m1 * 10 + m0) * 60 + s1 * 10 + s0;
  endfunction

  function automatic void model_step(input bit l, input bit ss, input bit t, input logic [15:0] p);
    m_pulse = 1'b0;
    case (m_mode)
      0: begin
        if (l) m_total = preset_secs(p);
        else if (ss && m_total != 0) m_mode = 1;
      end
      1: begin
        if (ss) m_mode = 2;
        else if (t) begin
          m_total = m_total - 1;
          if (m_total == 0) begin
            m_mode  = 3;
            m_pulse = 1'b1;
          end
        end
      end
      default: begin
        if (l) begin
          m_total = preset_secs(p);
          m_mode  = 0;
        end else if (ss) begin
          m_mode = (m_mode == 2) ? 1 : 0;
        end
      end
    endcase
  endfunction

  function automatic void model_reset();
    m_total = 0;
    m_mode  = 0;
    m_pulse = 1'b0;
  endfunction

  // {m1, m0, s1, s0, running, done, done_pulse}
  function automatic logic [18:0] expv();
    int mm, sc;
    mm = m_total / 60;
    sc = m_total % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10),
            (m_mode == 1), (m_mode == 3), m_pulse};
  endfunction

  function automatic logic [18:0] obsv();
    return {bus.min_s1, bus.min_s0, bus.sec_s1, bus.sec_s0,
            bus.running, bus.done, bus.done_pulse};
  endfunction

  // Apply one cycle of strobes, advance the model, then sample 1 time unit after the edge
  task automatic step(input bit l, input bit ss, input bit t, input logic [15:0] p);
    bus.load       = l;
    bus.start_stop = ss;
    bus.tick       = t;
    {bus.preset_m1, bus.preset_m0, bus.preset_s1, bus.preset_s0} = p;
    model_step(l, ss, t, p);
    @(posedge clk);
    #1;
    bus.load       = 1'b0;
    bus.start_stop = 1'b0;
    bus.tick       = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] e, o;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.start_stop = 1'b0; bus.tick = 1'b0;
    {bus.preset_m1, bus.preset_m0, bus.preset_s1, bus.preset_s0} = 16'h0;
    model_reset();
    #3;
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL reset_state: got %h expected %h", o, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a count
    step(1, 0, 0, 16'h0030);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL reset_mid_run: got %h expected %h", o, e); end
    #2 rst_n = 1'b1;
    step(0, 0, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL tick_after_reset: got %h expected %h", o, e); end

    step(1, 0, 0, 16'h7C6F);
    e = expv(); o = obsv(); tests_run++;
    if (o !== {4'd5, 4'd9, 4'd5, 4'd9, 3'b000}) begin
      tests_failed++; $display("FAIL clamp_load: got %h expected %h", o, {4'd5, 4'd9, 4'd5, 4'd9, 3'b000});
    end
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL clamp_model: got %h expected %h", o, e); end
  endtask

  task automatic test_borrow_chain();
    logic [18:0] e, o;
    step(1, 0, 0, 16'h1000);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL borrow_10_00: got %h expected %h", o, e); end
    step(0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0100);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL borrow_01_00: got %h expected %h", o, e); end
    step(0, 1, 0, 16'h0);
  endtask

  task automatic test_pause_resume();
    logic [18:0] e, o;
    step(1, 0, 0, 16'h0);       // PAUSE -> IDLE at 00:00
    step(1, 0, 0, 16'h0005);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL run_two_ticks: got %h expected %h", o, e); end
    step(0, 1, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL pause_drops_tick: got %h expected %h", o, e); end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL ticks_in_pause: got %h expected %h", o, e); end
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL resume_tick: got %h expected %h", o, e); end
    step(0, 1, 0, 16'h0);
  endtask

  task automatic test_expiry();
    logic [18:0] e, o;
    step(1, 0, 0, 16'h0002);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL expire_entry: got %h expected %h", o, e); end
    step(0, 0, 1, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL expire_pulse_once: got %h expected %h", o, e); end
    step(0, 0, 1, 16'h0);
    step(0, 0, 0, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL expire_hold: got %h expected %h", o, e); end
    step(0, 1, 0, 16'h0);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL expire_ack: got %h expected %h", o, e); end
  endtask

  task automatic test_guards();
    logic [18:0] e, o;
    step(0, 1, 0, 16'h0);       // IDLE at 00:00: start ignored
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL start_at_zero: got %h expected %h", o, e); end
    step(1, 0, 0, 16'h0041);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    step(1, 0, 1, 16'h1234);    // load in RUN ignored, tick still counts
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL load_in_run: got %h expected %h", o, e); end
    step(0, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0215);
    e = expv(); o = obsv(); tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL load_ss_in_pause: got %h expected %h", o, e); end
    step(1, 0, 0, 16'h0);
  endtask

  task automatic test_random();
    logic [18:0] e, o;
    logic [15:0] p;
    bit l, ss, t;
    for (int i = 0; i < 600; i++) begin
      l  = ($urandom_range(0, 19) == 0);
      ss = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 2) != 0);
      p  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : {12'h0, 4'($urandom_range(0, 9))};
      step(l, ss, t, p);
      e = expv(); o = obsv(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL random_cycle_%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_borrow_chain();
    test_pause_resume();
    test_expiry();
    test_guards();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/countdown_mmss.md
# countdown_mmss

Four-digit BCD countdown timer (MM:SS, 59:59 max) with a borrow chain. It is the count-down counterpart of the stopwatch's carry-chained up-counting digit stages. A preset is loaded, then the timer decrements once per 1 Hz tick enable under a start/stop FSM. It flags expiry at 00:00, and its digit outputs feed the existing 7-segment scan/display path.

## Interface
Parameters:
- none (digit ranges fixed: tens 0–5, units 0–9)

Ports:
- clk  in  1  system clock; all state on posedge clk
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- tick  in  1  one-cycle 1 Hz enable, synchronous to clk
- load  in  1  one-cycle pulse: copy preset into digits
- start_stop  in  1  one-cycle pulse (debounced upstream): run/pause toggle, also acknowledges DONE
- preset_m1  in  4  minutes tens preset, BCD
- preset_m0  in  4  minutes units preset, BCD
- preset_s1  in  4  seconds tens preset, BCD
- preset_s0  in  4  seconds units preset, BCD
- min_s1, min_s0, sec_s1, sec_s0  out  4 each  current digits, registered
- running  out  1  high while state is RUN
- done  out  1  high while state is DONE
- done_pulse  out  1  single-cycle pulse on entry to DONE

## Operation
- Reset (rst_n low, asynchronous): all digits 0, state IDLE, running=0, done=0, done_pulse=0.
- States: IDLE, RUN, PAUSE, DONE.
- Priority each cycle: load > start_stop > tick.
- IDLE:
  - load: digits <= clamped preset, stay IDLE.
  - start_stop with digits != 00:00: go to RUN.
  - start_stop at 00:00: ignored, stay IDLE.
- RUN:
  - load ignored.
  - start_stop: go to PAUSE; a tick in the same cycle is dropped.
  - tick alone: decrement by one second.
- PAUSE:
  - load: digits <= clamped preset, go to IDLE.
  - start_stop: go to RUN; a same-cycle tick is dropped.
  - tick ignored.
- DONE:
  - load: digits <= clamped preset, go to IDLE.
  - start_stop: go to IDLE; digits stay 00:00.
  - tick ignored.
- Clamping on load: tens digit >5 loads as 5; units digit >9 loads as 9 (e.g. preset 7,C,6,F → 59:59).
- Decrement (borrow chain):
  - sec_s0 0 → 9 with borrow, else −1.
  - On borrow, sec_s1 0 → 5 with borrow, else −1.
  - On borrow, min_s0 0 → 9 with borrow, else −1.
  - On borrow, min_s1 −1.
  - No borrow out of min_s1: RUN is never entered at 00:00, and RUN leaves at 00:00.
- Expiry: a decrement whose result is 00:00 moves the state to DONE in the same edge. done_pulse is high for exactly that one following cycle.
- Digits always hold legal BCD ranges. No other state changes digits.

## Timing
- All outputs are registered, with zero combinational input→output paths.
- tick at edge N in RUN: new digits visible after edge N.
- start_stop at edge N: running changes after edge N.
- Final decrement (00:01 → 00:00) at edge N, all visible after edge N:
  - digits = 00:00
  - running = 0
  - done = 1
  - done_pulse = 1 for that one cycle only
- done drops the cycle after the acknowledging start_stop or load.
- Reset asserted mid-RUN clears everything immediately (asynchronous). Release is synchronous to the next clk edge; the first tick after release has no effect (state is IDLE).

## Test plan
- Reset/load/clamp: assert rst_n=0 mid-count → digits 00:00, running=0, done=0. Then load 7,C,6,F → digits 59:59, state IDLE.
- Full borrow chain: load 10:00, start_stop, one tick → 09:59. Load 01:00 (after pause), run, one tick → 00:59.
- Pause/resume: load 00:05, start, 2 ticks → 00:03. start_stop + tick same cycle → 00:03 paused; 3 ticks in PAUSE → 00:03. start_stop, 1 tick → 00:02.
- Expiry: load 00:02, start, 2 ticks → 00:00 with done=1, done_pulse high exactly 1 cycle, running=0. Further ticks → no change. start_stop → done=0, IDLE.
- Guard cases:
  - start_stop at 00:00 in IDLE → stays IDLE, running=0.
  - load during RUN (at 00:40) → ignored, count continues.
  - load + start_stop same cycle in PAUSE → IDLE with preset loaded, running=0.
